calc_engine_np: RTL and testbench

- Parametrised next-generation calculator core: NUM_PORTS requesters share one pipelined ALU.
- Each requester uses the calc two-cycle protocol: command with operand 1, then operand 2.
- Per-port request queues decouple requesters from a round-robin arbiter feeding a 2-stage ALU pipeline.
- Responses are routed back to the originating port, with per-port backpressure.

---
 rtl/calc_engine_np.sv | 276 +++++++++++++++++++++++++++
 tb/tb_calc_engine_np.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_engine_np.sv
// calc_engine_np: multi-port calculator core.
// NUM_PORTS requesters share one two-stage ALU pipeline. Each port runs the
// two-cycle calc protocol: a command word with operand 1, then operand 2.
// Each port has its own request queue. A round-robin arbiter drains the
// queues, and every response is routed back to the port that issued it.
//
// Optional build macro: CALC_MULT_EN enables cmd 3 (unsigned multiply).
//
// Ports:
//   c_clk        rising-edge clock
//   reset        asynchronous active-low reset
//   req_cmd_in   per-port command, port p at [4p+3:4p]
//   req_data_in  per-port operand bus, port p at [DATA_W*p +: DATA_W]
//   out_resp     per-port response code: 00 none, 01 good, 10 error
//   out_data     per-port result, valid only while out_resp is nonzero
//   req_busy     port has QDEPTH commands outstanding
//
// Capture FSM (one per port):
//   state   | meaning
//   ST_IDLE | waiting for a command word with operand 1
//   ST_OP2  | operand 2 on the bus this cycle; push to the port queue
module calc_engine_np #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int QDEPTH    = 2
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
    output logic [2*NUM_PORTS-1:0]      out_resp,
    output logic [DATA_W*NUM_PORTS-1:0] out_data,
    output logic [NUM_PORTS-1:0]        req_busy
);
    localparam int SW = $clog2(DATA_W);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int IW = $clog2(NUM_PORTS);

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_MUL = 4'd3;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;
    localparam logic [1:0] RESP_GOOD = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    typedef enum logic {ST_IDLE, ST_OP2} cap_state_t;

    cap_state_t        state     [NUM_PORTS];
    cap_state_t        state_nxt [NUM_PORTS];
    logic [3:0]        cmd_in    [NUM_PORTS];
    logic [DATA_W-1:0] data_in   [NUM_PORTS];
    logic [3:0]        cmd_r     [NUM_PORTS];
    logic [DATA_W-1:0] op1_r     [NUM_PORTS];
    entry_t            q_mem     [NUM_PORTS][QDEPTH];
    logic [PW-1:0]     wr_ptr    [NUM_PORTS];
    logic [PW-1:0]     rd_ptr    [NUM_PORTS];
    logic [CW-1:0]     q_cnt     [NUM_PORTS];
    logic [CW-1:0]     out_cnt   [NUM_PORTS];
    logic [CW-1:0]     cnt_nxt   [NUM_PORTS];
    logic [NUM_PORTS-1:0] accept, push, pop, done, busy_r;

    logic [IW-1:0] rr_ptr, grant_idx;
    logic          grant_valid;
    int            idx;

    logic          s1_valid, s2_valid;
    entry_t        s1_entry;
    logic [IW-1:0] s1_port, s2_port;
    logic [1:0]    s2_resp, alu_resp;
    logic [DATA_W-1:0] s2_data, alu_data;
    logic [DATA_W:0]   sum;
`ifdef CALC_MULT_EN
    logic [2*DATA_W-1:0] prod;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (int'(p) == QDEPTH - 1) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            cmd_in[p]  = req_cmd_in[4*p +: 4];
            data_in[p] = req_data_in[DATA_W*p +: DATA_W];
        end
    end

    // Capture FSM: state register
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) state[p] <= ST_IDLE;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) state[p] <= state_nxt[p];
        end
    end

    // Capture FSM: next state. A command seen while busy is dropped.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_nxt[p] = state[p];
            case (state[p])
                ST_IDLE: if (cmd_in[p] != 4'd0 && !busy_r[p]) state_nxt[p] = ST_OP2;
                ST_OP2:  state_nxt[p] = ST_IDLE;
                default: state_nxt[p] = ST_IDLE;
            endcase
        end
    end

    // Capture FSM: outputs
    always_comb begin
        accept = '0;
        push   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            accept[p] = (state[p] == ST_IDLE) && (cmd_in[p] != 4'd0) && !busy_r[p];
            push[p]   = (state[p] == ST_OP2);
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                cmd_r[p] <= '0;
                op1_r[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (accept[p]) begin
                    cmd_r[p] <= cmd_in[p];
                    op1_r[p] <= data_in[p];
                end
            end
        end
    end

    // Queue storage needs no reset; q_cnt gates every read.
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) q_mem[p][wr_ptr[p]] <= '{cmd: cmd_r[p], a: op1_r[p], b: data_in[p]};
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            done[p]    = s2_valid && (s2_port == IW'(p));
            cnt_nxt[p] = out_cnt[p];
            if (accept[p] && !done[p])      cnt_nxt[p] = out_cnt[p] + 1'b1;
            else if (!accept[p] && done[p]) cnt_nxt[p] = out_cnt[p] - 1'b1;
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr[p]  <= '0;
                rd_ptr[p]  <= '0;
                q_cnt[p]   <= '0;
                out_cnt[p] <= '0;
            end
            busy_r <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (push[p]) wr_ptr[p] <= ptr_inc(wr_ptr[p]);
                if (pop[p])  rd_ptr[p] <= ptr_inc(rd_ptr[p]);
                if (push[p] && !pop[p])      q_cnt[p] <= q_cnt[p] + 1'b1;
                else if (!push[p] && pop[p]) q_cnt[p] <= q_cnt[p] - 1'b1;
                out_cnt[p] <= cnt_nxt[p];
                busy_r[p]  <= (cnt_nxt[p] == CW'(QDEPTH));
            end
        end
    end

    assign req_busy = busy_r;

    // Round-robin arbiter: first non-empty queue at or after rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        pop         = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!grant_valid && q_cnt[idx] != '0) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) pop[p] = grant_valid && (grant_idx == IW'(p));
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_entry <= '0;
            s1_port  <= '0;
        end else begin
            s1_valid <= grant_valid;
            if (grant_valid) begin
                s1_entry <= q_mem[grant_idx][rd_ptr[grant_idx]];
                s1_port  <= grant_idx;
                rr_ptr   <= (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_comb begin
        alu_resp = RESP_ERR;
        alu_data = '0;
        sum      = {1'b0, s1_entry.a} + {1'b0, s1_entry.b};
`ifdef CALC_MULT_EN
        prod     = {{DATA_W{1'b0}}, s1_entry.a} * {{DATA_W{1'b0}}, s1_entry.b};
`endif
        case (s1_entry.cmd)
            CMD_ADD: if (!sum[DATA_W]) begin
                alu_resp = RESP_GOOD;
                alu_data = sum[DATA_W-1:0];
            end
            CMD_SUB: if (s1_entry.a >= s1_entry.b) begin
                alu_resp = RESP_GOOD;
                alu_data = s1_entry.a - s1_entry.b;
            end
            CMD_SHL: begin
                alu_resp = RESP_GOOD;
                alu_data = s1_entry.a << s1_entry.b[SW-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_GOOD;
                alu_data = s1_entry.a >> s1_entry.b[SW-1:0];
            end
`ifdef CALC_MULT_EN
            CMD_MUL: if (prod[2*DATA_W-1:DATA_W] == '0) begin
                alu_resp = RESP_GOOD;
                alu_data = prod[DATA_W-1:0];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_resp  <= '0;
            s2_data  <= '0;
            s2_port  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_resp  <= alu_resp;
            s2_data  <= alu_data;
            s2_port  <= s1_port;
        end
    end

    always_comb begin
        out_resp = '0;
        out_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (done[p]) begin
                out_resp[2*p +: 2]           = s2_resp;
                out_data[DATA_W*p +: DATA_W] = s2_data;
            end
        end
    end

    logic unused_cmd_mul;
    assign unused_cmd_mul = ^CMD_MUL;
endmodule

// File: tb/tb_calc_engine_np.sv
module tb_calc_engine_np;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int QD = 2;

    logic           c_clk;
    logic           reset;
    logic [4*NP-1:0]  req_cmd_in;
    logic [DW*NP-1:0] req_data_in;
    logic [2*NP-1:0]  out_resp;
    logic [DW*NP-1:0] out_data;
    logic [NP-1:0]    req_busy;

    calc_engine_np #(.NUM_PORTS(NP), .DATA_W(DW), .QDEPTH(QD)) dut (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .out_resp(out_resp), .out_data(out_data), .req_busy(req_busy)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t sb [NP][$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   model_cnt [NP];
    bit   acc_pend  [NP];
    bit   dec_pend  [NP];
    bit   busy_seen = 0;

    task automatic chk(input string nm, input int p, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s port %0d: got %h required %h (cycle %0d)", nm, p, act, exp, cyc);
    endtask

    // Bench-side outstanding model: accepts and responses noted on the
    // falling edge take effect on the following rising edge.
    always @(posedge c_clk) begin
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (!reset) model_cnt[p] = 0;
            else model_cnt[p] = model_cnt[p] + int'(acc_pend[p]) - int'(dec_pend[p]);
            acc_pend[p] = 0;
            dec_pend[p] = 0;
        end
    end

    always @(negedge c_clk) begin
        logic [1:0]  r;
        logic [31:0] d;
        exp_t        e;
        for (int p = 0; p < NP; p++) begin
            r = out_resp[2*p +: 2];
            d = out_data[DW*p +: DW];
            chk("busy", p, 64'(req_busy[p]), 64'(model_cnt[p] == QD));
            if (req_busy[p]) busy_seen = 1;
            if (r == 2'b00) begin
                chk("idle_data", p, 64'(d), 64'd0);
            end else begin
                dec_pend[p] = 1;
                if (sb[p].size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp port %0d: got resp %b data %h, required no response (cycle %0d)", p, r, d, cyc);
                end else begin
                    e = sb[p].pop_front();
                    chk("resp", p, 64'(r), 64'(e.resp));
                    chk("data", p, 64'(d), 64'(e.data));
                    if (e.lat != 0) chk("latency", p, 64'(cyc - e.cyc), 64'(e.lat));
                end
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after operand 2.
    task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed, input int lat);
        exp_t e;
        int   guard = 0;
        while (req_busy[p]) begin
            @(negedge c_clk);
            guard++;
            if (guard > 40) begin
                n_checks++;
                $display("FAIL busy_timeout port %0d: got req_busy=1 for %0d cycles, required release", p, guard);
                return;
            end
        end
        req_cmd_in[4*p +: 4]   = c;
        req_data_in[DW*p +: DW] = a;
        acc_pend[p] = 1;
        @(negedge c_clk);
        req_cmd_in[4*p +: 4]   = 4'd0;
        req_data_in[DW*p +: DW] = b;
        e.resp = er; e.data = ed; e.lat = lat; e.cyc = cyc;
        sb[p].push_back(e);
        @(negedge c_clk);
    endtask

    function automatic void get_vec(input int i, output logic [3:0] c, output logic [31:0] a,
                                    output logic [31:0] b, output logic [1:0] r, output logic [31:0] d);
        case (i % 8)
            0: begin c = 4'd1; a = 32'd10;         b = 32'd20;         r = 2'b01; d = 32'd30;         end
            1: begin c = 4'd2; a = 32'd100;        b = 32'd1;          r = 2'b01; d = 32'd99;         end
            2: begin c = 4'd5; a = 32'd3;          b = 32'd8;          r = 2'b01; d = 32'h300;        end
            3: begin c = 4'd6; a = 32'hF0;         b = 32'd4;          r = 2'b01; d = 32'hF;          end
            4: begin c = 4'd1; a = 32'h8000_0000;  b = 32'h8000_0000;  r = 2'b10; d = 32'd0;          end
            5: begin c = 4'd2; a = 32'd0;          b = 32'd1;          r = 2'b10; d = 32'd0;          end
            6: begin c = 4'd9; a = 32'd1;          b = 32'd1;          r = 2'b10; d = 32'd0;          end
            default: begin c = 4'd1; a = 32'h7FFF_FFFF; b = 32'd1;     r = 2'b01; d = 32'h8000_0000;  end
        endcase
    endfunction

    task automatic run_stream(input int p, input int n);
        logic [3:0] c; logic [31:0] a, b, d; logic [1:0] r;
        for (int i = 0; i < n; i++) begin
            get_vec(p + i, c, a, b, r, d);
            issue(p, c, a, b, r, d, 0);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && guard < 100) begin
            @(negedge c_clk);
            guard++;
        end
        repeat (2) @(negedge c_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        for (int p = 0; p < NP; p++) begin model_cnt[p] = 0; acc_pend[p] = 0; dec_pend[p] = 0; end
        reset = 1'b0;
        req_cmd_in = '0;
        req_data_in = '0;
        repeat (3) @(negedge c_clk);
        chk("reset_resp", 0, 64'(out_resp), 64'd0);
        chk("reset_data_lo", 0, out_data[63:0], 64'd0);
        chk("reset_data_hi", 0, out_data[127:64], 64'd0);
        chk("reset_busy", 0, 64'(req_busy), 64'd0);
        reset = 1'b1;
        @(negedge c_clk);

        issue(0, 4'd1, 32'h1, 32'h2, 2'b01, 32'h3, 3);
        issue(1, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'b10, 32'h0, 3);
        issue(1, 4'd2, 32'd5, 32'd7, 2'b10, 32'h0, 3);
        issue(1, 4'd2, 32'd7, 32'd5, 2'b01, 32'h2, 3);
        issue(1, 4'd2, 32'd7, 32'd7, 2'b01, 32'h0, 3);
        issue(1, 4'd1, 32'hFFFF_FFFE, 32'h1, 2'b01, 32'hFFFF_FFFF, 3);
        issue(2, 4'd5, 32'h1, 32'h24, 2'b01, 32'h10, 3);
        issue(2, 4'd6, 32'h8000_0000, 32'd31, 2'b01, 32'h1, 3);
        issue(2, 4'hC, 32'h1, 32'h2, 2'b10, 32'h0, 3);
        issue(2, 4'd5, 32'hFFFF_FFFF, 32'd0, 2'b01, 32'hFFFF_FFFF, 3);
        issue(2, 4'd5, 32'h1, 32'd31, 2'b01, 32'h8000_0000, 3);
        issue(2, 4'd4, 32'h1, 32'h1, 2'b10, 32'h0, 3);
        issue(2, 4'hF, 32'h1, 32'h1, 2'b10, 32'h0, 3);
        issue(3, 4'd1, 32'h0, 32'h0, 2'b01, 32'h0, 3);
        drain();

        // rr_ptr is 0 here: all four op2 together answer on 0,1,2,3 back to back.
        fork
            issue(0, 4'd1, 32'h10, 32'h01, 2'b01, 32'h11, 3);
            issue(1, 4'd1, 32'h20, 32'h02, 2'b01, 32'h22, 4);
            issue(2, 4'd1, 32'h30, 32'h03, 2'b01, 32'h33, 5);
            issue(3, 4'd1, 32'h40, 32'h04, 2'b01, 32'h44, 6);
        join
        drain();
        issue(0, 4'd1, 32'h100, 32'h100, 2'b01, 32'h200, 3);
        drain();
        // rr_ptr is 1: port 3 wins before port 0 (wraparound).
        fork
            issue(0, 4'd1, 32'd5, 32'd5, 2'b01, 32'hA, 4);
            issue(3, 4'd2, 32'd9, 32'd4, 2'b01, 32'h5, 3);
        join
        drain();

        fork
            run_stream(0, 6);
            run_stream(1, 6);
            run_stream(2, 6);
            run_stream(3, 6);
        join
        drain();

`ifdef CALC_MULT_EN
        issue(0, 4'd3, 32'd3, 32'd5, 2'b01, 32'd15, 3);
        issue(0, 4'd3, 32'h1_0000, 32'h1_0000, 2'b10, 32'h0, 3);
        issue(0, 4'd3, 32'hFFFF, 32'hFFFF, 2'b01, 32'hFFFE_0001, 3);
`else
        issue(0, 4'd3, 32'd3, 32'd5, 2'b10, 32'h0, 3);
`endif
        drain();

        // Asynchronous reset with three commands still in flight.
        fork
            issue(0, 4'd1, 32'd1, 32'd1, 2'b01, 32'd2, 0);
            issue(1, 4'd1, 32'd2, 32'd2, 2'b01, 32'd4, 0);
            issue(2, 4'd1, 32'd3, 32'd3, 2'b01, 32'd6, 0);
            issue(3, 4'd1, 32'd4, 32'd4, 2'b01, 32'd8, 0);
        join
        found = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_resp != '0) begin found = 1; break; end
            @(negedge c_clk);
        end
        chk("first_resp_before_reset", 0, 64'(found), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_resp", 0, 64'(out_resp), 64'd0);
        chk("async_reset_data_lo", 0, out_data[63:0], 64'd0);
        chk("async_reset_data_hi", 0, out_data[127:64], 64'd0);
        chk("async_reset_busy", 0, 64'(req_busy), 64'd0);
        for (int p = 0; p < NP; p++) begin
            sb[p].delete();
            model_cnt[p] = 0; acc_pend[p] = 0; dec_pend[p] = 0;
        end
        repeat (2) @(negedge c_clk);
        reset = 1'b1;
        repeat (12) @(negedge c_clk);
        issue(1, 4'd1, 32'd1, 32'd1, 2'b01, 32'd2, 3);
        drain();

        for (int p = 0; p < NP; p++) chk("sb_empty", p, 64'(sb[p].size()), 64'd0);
        chk("busy_seen", 0, 64'(busy_seen), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
